// File: rtl/rgb_video_capture.sv
// Receive side of a parallel RGB video bus: samples vs/de/rgb, emits an x/y tagged pixel
// stream, measures active width/height per frame and asserts lock once timing is stable.
module rgb_video_capture #(
  parameter int H_W           = 11,
  parameter int V_W           = 11,
  parameter bit VS_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vs,
  input  logic           de,
  input  logic [7:0]     rgb_r,
  input  logic [7:0]     rgb_g,
  input  logic [7:0]     rgb_b,
  output logic           pix_valid,
  output logic [23:0]    pix_data,
  output logic [H_W-1:0] pix_x,
  output logic [V_W-1:0] pix_y,
  output logic           pix_sof,
  output logic           pix_eol,
  output logic           frame_done,
  output logic [H_W-1:0] meas_width,
  output logic [V_W-1:0] meas_height,
  output logic           locked,
  output logic           err_line
);

  localparam int LC_W = $clog2(LOCK_FRAMES + 1);

  logic            vact_s1_q, vact_s1_d, vact_s2_q, vact_s2_d;
  logic            de_s1_q, de_s1_d, de_s2_q, de_s2_d;
  logic [23:0]     rgb_s1_q, rgb_s1_d, rgb_s2_q, rgb_s2_d;
  logic [H_W-1:0]  x_q, x_d, ref_width_q, ref_width_d, meas_width_q, meas_width_d, pix_x_q, pix_x_d;
  logic [V_W-1:0]  y_q, y_d, meas_height_q, meas_height_d, pix_y_q, pix_y_d;
  logic            have_ref_q, have_ref_d, err_q, err_d, ovf_q, ovf_d;
  logic            open_q, open_d, discard_q, discard_d;
  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d, err_line_q, err_line_d, frame_done_q, frame_done_d;
  logic            pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
  logic [23:0]     pix_data_q, pix_data_d;

  logic            vs_start, eol, partial, x_max, good;
  logic [H_W-1:0]  line_len;
  logic [V_W-1:0]  y_eff;

  always_comb begin
    vact_s1_d = VS_ACTIVE_LOW ? ~vs : vs;
    de_s1_d   = de;
    rgb_s1_d  = {rgb_r, rgb_g, rgb_b};
    vact_s2_d = vact_s1_q;
    de_s2_d   = de_s1_q;
    rgb_s2_d  = rgb_s1_q;

    vs_start = vact_s1_q & ~vact_s2_q;
    eol      = de_s2_q & ~de_s1_q;
    partial  = vs_start & de_s2_q & de_s1_q;
    x_max    = (x_q == {H_W{1'b1}});
    line_len = x_q + H_W'(1);
    y_eff    = partial ? '0 : y_q;
    good     = 1'b0;

    x_d           = x_q;
    y_d           = y_q;
    ref_width_d   = ref_width_q;
    have_ref_d    = have_ref_q;
    err_d         = err_q;
    ovf_d         = ovf_q;
    open_d        = open_q;
    discard_d     = discard_q;
    lock_cnt_d    = lock_cnt_q;
    locked_d      = locked_q;
    err_line_d    = err_line_q;
    meas_width_d  = meas_width_q;
    meas_height_d = meas_height_q;
    frame_done_d  = 1'b0;

    pix_valid_d = de_s2_q;
    pix_data_d  = rgb_s2_q;
    pix_x_d     = x_q;
    pix_y_d     = y_eff;
    pix_sof_d   = de_s2_q & (x_q == '0) & (y_eff == '0);
    pix_eol_d   = eol;

    if (de_s2_q) begin
      if (x_max) ovf_d = 1'b1;
      if (eol) x_d = '0;
      else if (!x_max) x_d = x_q + H_W'(1);
    end

    // A line cut by vsync is still output but never feeds the statistics.
    if (eol) begin
      if (discard_q) begin
        discard_d = 1'b0;
      end else begin
        if (!have_ref_q) begin
          ref_width_d = line_len;
          have_ref_d  = 1'b1;
        end else if (line_len != ref_width_q) begin
          err_d = 1'b1;
        end
        if (y_q != {V_W{1'b1}}) y_d = y_q + V_W'(1);
      end
    end

    // Frame close uses the post-eol values so a coincident last line is included.
    if (vs_start) begin
      if (open_q) begin
        frame_done_d  = 1'b1;
        meas_width_d  = ref_width_d;
        meas_height_d = y_d;
        err_line_d    = err_d | ovf_d;
        good = ~(err_d | ovf_d) & (y_d != '0) & (ref_width_d == meas_width_q) & (y_d == meas_height_q);
        if (!good) lock_cnt_d = '0;
        else if (lock_cnt_q != LC_W'(LOCK_FRAMES)) lock_cnt_d = lock_cnt_q + LC_W'(1);
        locked_d = (lock_cnt_d == LC_W'(LOCK_FRAMES));
      end
      open_d      = 1'b1;
      y_d         = '0;
      ref_width_d = '0;
      have_ref_d  = 1'b0;
      err_d       = partial;
      ovf_d       = 1'b0;
      discard_d   = partial;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vact_s1_q <= 1'b0;  vact_s2_q <= 1'b0;
      de_s1_q   <= 1'b0;  de_s2_q   <= 1'b0;
      rgb_s1_q  <= '0;    rgb_s2_q  <= '0;
      x_q <= '0;  y_q <= '0;  ref_width_q <= '0;  have_ref_q <= 1'b0;
      err_q <= 1'b0;  ovf_q <= 1'b0;  open_q <= 1'b0;  discard_q <= 1'b0;
      lock_cnt_q <= '0;  locked_q <= 1'b0;  err_line_q <= 1'b0;  frame_done_q <= 1'b0;
      meas_width_q <= '0;  meas_height_q <= '0;
      pix_valid_q <= 1'b0;  pix_data_q <= '0;  pix_x_q <= '0;  pix_y_q <= '0;
      pix_sof_q <= 1'b0;  pix_eol_q <= 1'b0;
    end else begin
      vact_s1_q <= vact_s1_d;  vact_s2_q <= vact_s2_d;
      de_s1_q   <= de_s1_d;    de_s2_q   <= de_s2_d;
      rgb_s1_q  <= rgb_s1_d;   rgb_s2_q  <= rgb_s2_d;
      x_q <= x_d;  y_q <= y_d;  ref_width_q <= ref_width_d;  have_ref_q <= have_ref_d;
      err_q <= err_d;  ovf_q <= ovf_d;  open_q <= open_d;  discard_q <= discard_d;
      lock_cnt_q <= lock_cnt_d;  locked_q <= locked_d;  err_line_q <= err_line_d;
      frame_done_q <= frame_done_d;
      meas_width_q <= meas_width_d;  meas_height_q <= meas_height_d;
      pix_valid_q <= pix_valid_d;  pix_data_q <= pix_data_d;  pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;  pix_sof_q <= pix_sof_d;  pix_eol_q <= pix_eol_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eol     = pix_eol_q;
  assign frame_done  = frame_done_q;
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;
  assign locked      = locked_q;
  assign err_line    = err_line_q;

endmodule

// File: tb/tb_rgb_video_capture.sv
// Directed-random bench for rgb_video_capture: frames are described as lists of line
// lengths and the expected pixel stream / frame results come from a queue-based model.
module tb_rgb_video_capture;

  localparam int H_W           = 11;
  localparam int V_W           = 11;
  localparam bit VS_ACTIVE_LOW = 1'b1;
  localparam int LOCK_FRAMES   = 2;

  logic           clk, rst_n, vs, de;
  logic [7:0]     rgb_r, rgb_g, rgb_b;
  logic           pix_valid, pix_sof, pix_eol, frame_done, locked, err_line;
  logic [23:0]    pix_data;
  logic [H_W-1:0] pix_x, meas_width;
  logic [V_W-1:0] pix_y, meas_height;

  rgb_video_capture #(
    .H_W(H_W), .V_W(V_W), .VS_ACTIVE_LOW(VS_ACTIVE_LOW), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
    .meas_width(meas_width), .meas_height(meas_height), .locked(locked), .err_line(err_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] data;
    int          x;
    int          y;
    bit          sof;
    bit          eol;
  } pix_t;

  typedef struct {
    int due;
    int w;
    int h;
    bit err;
    bit lck;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];
  int   cur_lines[$];
  pix_t hold;
  bit   hold_valid;
  int   cyc, checks, errors;
  int   line_pos, row, prev_w, prev_h, lock_cnt;
  bit   frame_open, prev_dv, last_vact;
  int   v_w, v_h;
  bit   v_err, v_lock;
  bit          use_fixed;
  logic [23:0] fixed_rgb;

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic resetModel();
    pq.delete();
    fq.delete();
    cur_lines.delete();
    hold_valid = 1'b0;
    line_pos = 0;  row = 0;  prev_w = 0;  prev_h = 0;  lock_cnt = 0;
    frame_open = 1'b0;  prev_dv = 1'b0;  last_vact = 1'b0;
    v_w = 0;  v_h = 0;  v_err = 1'b0;  v_lock = 1'b0;
  endtask

  task automatic checkOutput();
    pix_t p;
    frm_t f;
    bit   ev, ed;
    ev = 1'b0;
    ed = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      p  = pq.pop_front();
      ev = 1'b1;
    end
    if (fq.size() > 0 && fq[0].due == cyc) begin
      f  = fq.pop_front();
      ed = 1'b1;
      v_w = f.w;  v_h = f.h;  v_err = f.err;  v_lock = f.lck;
    end
    expectEq("pix_valid", 32'(pix_valid), 32'(ev));
    expectEq("pix_sof", 32'(pix_sof), ev ? 32'(p.sof) : 32'd0);
    expectEq("pix_eol", 32'(pix_eol), ev ? 32'(p.eol) : 32'd0);
    if (ev) begin
      expectEq("pix_data", 32'(pix_data), 32'(p.data));
      expectEq("pix_x", 32'(pix_x), 32'(p.x));
      expectEq("pix_y", 32'(pix_y), 32'(p.y));
    end
    expectEq("frame_done", 32'(frame_done), 32'(ed));
    expectEq("meas_width", 32'(meas_width), 32'(v_w));
    expectEq("meas_height", 32'(meas_height), 32'(v_h));
    expectEq("err_line", 32'(err_line), 32'(v_err));
    expectEq("locked", 32'(locked), 32'(v_lock));
    if (!rst_n) begin
      expectEq("rst_pix_data", 32'(pix_data), 32'd0);
      expectEq("rst_pix_x", 32'(pix_x), 32'd0);
      expectEq("rst_pix_y", 32'(pix_y), 32'd0);
    end
  endtask

  // One pixel-clock step: update the model from the pin values, drive, clock, compare.
  task automatic applyStimulus(input bit vact, input bit dv, input logic [23:0] rgb);
    frm_t f;
    int   w;
    bit   e, good;
    if (!rst_n) begin
      resetModel();
    end else begin
      if (hold_valid) begin
        hold.eol = !dv;
        pq.push_back(hold);
        hold_valid = 1'b0;
      end
      if (prev_dv && !dv) begin
        cur_lines.push_back(line_pos);
        line_pos = 0;
        row++;
      end
      if (vact && !last_vact) begin
        if (frame_open) begin
          w = (cur_lines.size() > 0) ? cur_lines[0] : 0;
          e = 1'b0;
          foreach (cur_lines[i]) if (cur_lines[i] != w) e = 1'b1;
          good = !e && cur_lines.size() > 0 && w == prev_w && cur_lines.size() == prev_h;
          lock_cnt = good ? ((lock_cnt < LOCK_FRAMES) ? lock_cnt + 1 : lock_cnt) : 0;
          f.due = cyc + 2;
          f.w   = w;
          f.h   = cur_lines.size();
          f.err = e;
          f.lck = (lock_cnt == LOCK_FRAMES);
          fq.push_back(f);
          prev_w = w;
          prev_h = f.h;
        end
        frame_open = 1'b1;
        cur_lines.delete();
        row = 0;
      end
      if (dv) begin
        hold.due  = cyc + 3;
        hold.data = rgb;
        hold.x    = line_pos;
        hold.y    = row;
        hold.sof  = (line_pos == 0 && row == 0);
        hold.eol  = 1'b0;
        hold_valid = 1'b1;
        line_pos++;
      end
      prev_dv   = dv;
      last_vact = vact;
    end
    vs = VS_ACTIVE_LOW ? ~vact : vact;
    de = dv;
    {rgb_r, rgb_g, rgb_b} = rgb;
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic sendLine(input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      logic [23:0] d;
      d = 24'($urandom());
      if (use_fixed && i == 0) begin
        d = fixed_rgb;
        use_fixed = 1'b0;
      end
      applyStimulus(1'b0, 1'b1, d);
    end
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 1'b0, 24'($urandom()));
  endtask

  task automatic vsPulse();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 24'($urandom()));
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 24'($urandom()));
  endtask

  // tight: the last line's de fall coincides with the vsync active edge.
  task automatic sendFrame(input int w, input int h, input int bad_row, input int bad_len, input bit tight);
    int len, gap;
    for (int r = 0; r < h; r++) begin
      len = (r == bad_row) ? bad_len : w;
      gap = (tight && r == h - 1) ? 0 : $urandom_range(2, 6);
      sendLine(len, gap);
    end
    vsPulse();
  endtask

  initial begin
    checks = 0;  errors = 0;  cyc = 0;
    use_fixed = 1'b0;  fixed_rgb = 24'h123456;
    rst_n = 1'b0;
    resetModel();
    vs = VS_ACTIVE_LOW;  de = 1'b0;  rgb_r = '0;  rgb_g = '0;  rgb_b = '0;

    $display("[TB] reset with toggling inputs");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom()));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 24'h0);

    $display("[TB] three 8x4 frames");
    vsPulse();
    use_fixed = 1'b1;
    for (int i = 0; i < 3; i++) sendFrame(8, 4, -1, 0, 1'b0);
    expectEq("t2_meas_w", 32'(meas_width), 32'd8);
    expectEq("t2_meas_h", 32'(meas_height), 32'd4);
    expectEq("t2_locked", 32'(locked), 32'd1);

    $display("[TB] one short line in a locked stream");
    sendFrame(8, 4, 2, 7, 1'b0);
    expectEq("t3_err_line", 32'(err_line), 32'd1);
    expectEq("t3_unlocked", 32'(locked), 32'd0);
    sendFrame(8, 4, -1, 0, 1'b0);
    sendFrame(8, 4, -1, 0, 1'b0);
    expectEq("t3_relocked", 32'(locked), 32'd1);
    expectEq("t3_err_clear", 32'(err_line), 32'd0);

    $display("[TB] resolution change to 6x3");
    sendFrame(6, 3, -1, 0, 1'b0);
    expectEq("t4_meas_w", 32'(meas_width), 32'd6);
    expectEq("t4_meas_h", 32'(meas_height), 32'd3);
    expectEq("t4_unlocked", 32'(locked), 32'd0);
    sendFrame(6, 3, -1, 0, 1'b0);
    sendFrame(6, 3, -1, 0, 1'b0);
    expectEq("t4_relocked", 32'(locked), 32'd1);

    $display("[TB] frame with zero lines");
    vsPulse();
    expectEq("zl_meas_h", 32'(meas_height), 32'd0);
    expectEq("zl_unlocked", 32'(locked), 32'd0);

    $display("[TB] vsync edge on last de fall");
    sendFrame(8, 4, -1, 0, 1'b1);
    expectEq("t5_meas_h", 32'(meas_height), 32'd4);
    sendFrame(8, 4, -1, 0, 1'b1);
    expectEq("t5_meas_h2", 32'(meas_height), 32'd4);

    $display("[TB] reset mid-line");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 24'($urandom()));
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 24'($urandom()));
    expectEq("t6_valid_low", 32'(pix_valid), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 24'($urandom()));
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 24'($urandom()));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 24'($urandom()));
    vsPulse();
    expectEq("t6_open_no_done", 32'(meas_height), 32'd0);
    sendFrame(8, 4, -1, 0, 1'b0);
    sendFrame(8, 4, -1, 0, 1'b0);
    expectEq("t6_not_yet", 32'(locked), 32'd0);
    sendFrame(8, 4, -1, 0, 1'b0);
    expectEq("t6_locked", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
